// File: rtl/ddc_mixer_multilane.sv
// ---------------------------------------------------------------------------
// ddc_mixer_multilane
//   Multi-lane digital down-conversion mixer. Each beat carries LANES real
//   samples; lane k is mixed with a complex exponential at phase
//   acc + k*inc, producing I = x*cos and Q = +/-x*sin. Products are rounded
//   half-up with a selectable extra gain of 2^i_gain_shift, then saturated.
//   Fixed 5-cycle latency, no backpressure.
//
// Ports
//   i_clock        sole clock
//   i_reset_n      asynchronous active-low reset
//   i_data         LANES x WIDTH real samples, lane 0 (oldest) in the LSBs
//   i_valid        beat qualifier for i_data
//   i_phase_inc    per-sample phase increment (mod 2^PHASE_WIDTH)
//   i_phase_load   latch i_phase_inc and zero the phase accumulator
//   i_gain_shift   extra gain exponent, travels with the beat
//   i_conj         1: Q = -x*sin (mix by e^-jθ), travels with the beat
//   i_sat_clear    zero the saturation counter
//   o_inph/o_quad  I/Q per lane, same packing as i_data, held between beats
//   o_valid        output beat qualifier
//   o_sat_count    beats with any saturated lane/component, sticky at max
// ---------------------------------------------------------------------------

// Per-lane datapath: coefficient lookup, multiply, round, saturate.
// Stage enables come from the shared valid shift register in the top.
module ddc_mixer_lane #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 18,
    parameter int LUT_BITS   = 10
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_en_s2,
    input  logic                        i_en_s3,
    input  logic                        i_en_s4,
    input  logic                        i_en_s5,
    input  logic [LUT_BITS-1:0]         i_idx,
    input  logic signed [WIDTH-1:0]     i_x,
    input  logic [1:0]                  i_gain,
    input  logic                        i_conj,
    output logic signed [WIDTH-1:0]     o_inph,
    output logic signed [WIDTH-1:0]     o_quad,
    output logic                        o_sat
);
    localparam int DEPTH = 1 << LUT_BITS;
    localparam int PW    = WIDTH + COEF_WIDTH;
    localparam int RW    = PW + 1;               // headroom for the rounding add
    localparam int SW    = $clog2(COEF_WIDTH) + 1;

    function automatic logic signed [COEF_WIDTH-1:0] f_coef(input int idx, input bit is_sin);
        real ang;
        real amp;
        real v;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(DEPTH);
        amp = (2.0 ** (COEF_WIDTH - 1)) - 1.0;
        v   = amp * (is_sin ? $sin(ang) : $cos(ang));
        v   = (v >= 0.0) ? v + 0.5 : v - 0.5;   // round to nearest, ties away from zero
        return COEF_WIDTH'($rtoi(v));
    endfunction

    // {saturated, value}: fits iff every bit above the sign position matches the sign.
    function automatic logic [WIDTH:0] f_sat(input logic signed [RW-1:0] y);
        if (y[RW-1:WIDTH-1] == {(RW-WIDTH+1){y[RW-1]}})
            return {1'b0, y[WIDTH-1:0]};
        else if (y[RW-1])
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic signed [COEF_WIDTH-1:0] w_cos_rom [DEPTH];
    logic signed [COEF_WIDTH-1:0] w_sin_rom [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_cos_rom[gi] = f_coef(gi, 1'b0);
            assign w_sin_rom[gi] = f_coef(gi, 1'b1);
        end
    endgenerate

    logic signed [WIDTH-1:0]      r_x_s2;
    logic signed [COEF_WIDTH-1:0] r_cos_s2, r_sin_s2;
    logic signed [PW-1:0]         r_pi_s3, r_pq_s3;
    logic signed [RW-1:0]         r_yi_s4, r_yq_s4;

    logic [SW-1:0]                w_sh;
    logic signed [RW-1:0]         w_half, w_pq, w_yi, w_yq;
    logic [WIDTH:0]               w_si, w_sq;

    always_comb begin
        w_sh   = SW'(COEF_WIDTH - 1) - SW'(i_gain);
        w_half = RW'(1) <<< (w_sh - SW'(1));
        // Conjugation negates the full-width product, before rounding.
        w_pq   = i_conj ? -RW'(r_pq_s3) : RW'(r_pq_s3);
        w_yi   = (RW'(r_pi_s3) + w_half) >>> w_sh;
        w_yq   = (w_pq + w_half) >>> w_sh;
        w_si   = f_sat(r_yi_s4);
        w_sq   = f_sat(r_yq_s4);
    end

    assign o_sat = w_si[WIDTH] | w_sq[WIDTH];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x_s2   <= '0;
            r_cos_s2 <= '0;
            r_sin_s2 <= '0;
            r_pi_s3  <= '0;
            r_pq_s3  <= '0;
            r_yi_s4  <= '0;
            r_yq_s4  <= '0;
            o_inph   <= '0;
            o_quad   <= '0;
        end else begin
            if (i_en_s2) begin
                r_x_s2   <= i_x;
                r_cos_s2 <= w_cos_rom[i_idx];
                r_sin_s2 <= w_sin_rom[i_idx];
            end
            if (i_en_s3) begin
                r_pi_s3 <= PW'(r_x_s2) * PW'(r_cos_s2);
                r_pq_s3 <= PW'(r_x_s2) * PW'(r_sin_s2);
            end
            if (i_en_s4) begin
                r_yi_s4 <= w_yi;
                r_yq_s4 <= w_yq;
            end
            if (i_en_s5) begin
                o_inph <= w_si[WIDTH-1:0];
                o_quad <= w_sq[WIDTH-1:0];
            end
        end
    end
endmodule

module ddc_mixer_multilane #(
    parameter int WIDTH       = 16,
    parameter int LANES       = 2,
    parameter int COEF_WIDTH  = 18,
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_BITS    = 10
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [LANES*WIDTH-1:0]    i_data,
    input  logic                      i_valid,
    input  logic [PHASE_WIDTH-1:0]    i_phase_inc,
    input  logic                      i_phase_load,
    input  logic [1:0]                i_gain_shift,
    input  logic                      i_conj,
    input  logic                      i_sat_clear,
    output logic [LANES*WIDTH-1:0]    o_inph,
    output logic [LANES*WIDTH-1:0]    o_quad,
    output logic                      o_valid,
    output logic [15:0]               o_sat_count
);
    localparam int STAGES = 5;

    // Bit n: a beat occupies stage n (1 input reg .. 5 output reg).
    logic [STAGES:1]                     r_vld_pipe;
    logic [PHASE_WIDTH-1:0]              r_acc, r_inc;
    logic [LANES-1:0][WIDTH-1:0]         r_x_s1;
    logic [LANES-1:0][LUT_BITS-1:0]      r_idx_s1;
    logic [1:0]                          r_gain_s1, r_gain_s2, r_gain_s3;
    logic                                r_conj_s1, r_conj_s2, r_conj_s3;
    logic [15:0]                         r_sat_count;

    logic [PHASE_WIDTH-1:0]              w_acc_eff, w_inc_eff;
    logic [LANES-1:0][LUT_BITS-1:0]      w_idx;
    logic [LANES-1:0][WIDTH-1:0]         w_inph, w_quad;
    logic [LANES-1:0]                    w_sat;
    logic                                w_beat_sat;

    // A load coincident with a beat applies to that beat: phase 0, new increment.
    assign w_acc_eff = i_phase_load ? '0 : r_acc;
    assign w_inc_eff = i_phase_load ? i_phase_inc : r_inc;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_idx[k] = LUT_BITS'((w_acc_eff + PHASE_WIDTH'(k) * w_inc_eff) >> (PHASE_WIDTH - LUT_BITS));
        end
    end

    assign w_beat_sat = r_vld_pipe[STAGES-1] & (|w_sat);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld_pipe  <= '0;
            r_acc       <= '0;
            r_inc       <= '0;
            r_x_s1      <= '0;
            r_idx_s1    <= '0;
            r_gain_s1   <= '0;
            r_gain_s2   <= '0;
            r_gain_s3   <= '0;
            r_conj_s1   <= 1'b0;
            r_conj_s2   <= 1'b0;
            r_conj_s3   <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_valid};

            if (i_phase_load)
                r_inc <= i_phase_inc;
            if (i_valid)
                r_acc <= w_acc_eff + PHASE_WIDTH'(LANES) * w_inc_eff;
            else if (i_phase_load)
                r_acc <= '0;

            if (i_valid) begin
                r_x_s1    <= i_data;
                r_idx_s1  <= w_idx;
                r_gain_s1 <= i_gain_shift;
                r_conj_s1 <= i_conj;
            end
            if (r_vld_pipe[1]) begin
                r_gain_s2 <= r_gain_s1;
                r_conj_s2 <= r_conj_s1;
            end
            if (r_vld_pipe[2]) begin
                r_gain_s3 <= r_gain_s2;
                r_conj_s3 <= r_conj_s2;
            end

            // A clear coinciding with a saturating beat still counts that beat.
            if (i_sat_clear)
                r_sat_count <= w_beat_sat ? 16'd1 : 16'd0;
            else if (w_beat_sat && r_sat_count != 16'hFFFF)
                r_sat_count <= r_sat_count + 16'd1;
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < LANES; gk++) begin : g_lane
            ddc_mixer_lane #(
                .WIDTH      (WIDTH),
                .COEF_WIDTH (COEF_WIDTH),
                .LUT_BITS   (LUT_BITS)
            ) u_lane (
                .i_clock   (i_clock),
                .i_reset_n (i_reset_n),
                .i_en_s2   (r_vld_pipe[1]),
                .i_en_s3   (r_vld_pipe[2]),
                .i_en_s4   (r_vld_pipe[3]),
                .i_en_s5   (r_vld_pipe[4]),
                .i_idx     (r_idx_s1[gk]),
                .i_x       (r_x_s1[gk]),
                .i_gain    (r_gain_s3),
                .i_conj    (r_conj_s3),
                .o_inph    (w_inph[gk]),
                .o_quad    (w_quad[gk]),
                .o_sat     (w_sat[gk])
            );
        end
    endgenerate

    assign o_inph      = w_inph;
    assign o_quad      = w_quad;
    assign o_valid     = r_vld_pipe[STAGES];
    assign o_sat_count = r_sat_count;
endmodule

// File: tb/tb_ddc_mixer_multilane.sv
// ---------------------------------------------------------------------------
// tb_ddc_mixer_multilane
//   Directed bench for ddc_mixer_multilane (WIDTH=16, LANES=2, COEF_WIDTH=18,
//   PHASE_WIDTH=32, LUT_BITS=10). Single-beat vectors come from a table of
//   hand-computed results; streams, saturation-counter clear, reset with
//   beats in flight and counter stickiness are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ddc_mixer_multilane;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data;
    logic        valid, load, conj, sclr;
    logic [31:0] inc;
    logic [1:0]  gain;
    logic [31:0] inph, quad;
    logic        ovalid;
    logic [15:0] scnt;

    always #5 clk = ~clk;

    ddc_mixer_multilane dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_data       (data),
        .i_valid      (valid),
        .i_phase_inc  (inc),
        .i_phase_load (load),
        .i_gain_shift (gain),
        .i_conj       (conj),
        .i_sat_clear  (sclr),
        .o_inph       (inph),
        .o_quad       (quad),
        .o_valid      (ovalid),
        .o_sat_count  (scnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [15:0] i0, q0, i1, q1;
        int                 c;
    } out_t;

    out_t oq[$];
    bit   mon_en = 1'b1;

    always @(negedge clk) begin
        out_t o;
        if (mon_en && ovalid) begin
            o.i0 = inph[15:0];  o.i1 = inph[31:16];
            o.q0 = quad[15:0];  o.q1 = quad[31:16];
            o.c  = cyc;
            oq.push_back(o);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_q(input string nm);
        int t = 0;
        while (oq.size() == 0 && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        if (oq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s.timeout: got no output beat, required one within 40 cycles", nm);
        end
    endtask

    task automatic chk_out(input string nm, input int dcyc, input int ei0, input int eq0,
                           input int ei1, input int eq1);
        out_t o;
        wait_q(nm);
        if (oq.size() > 0) begin
            o = oq.pop_front();
            chk({nm, ".lat"}, o.c - dcyc, 5);
            chk({nm, ".i0"}, o.i0, ei0);
            chk({nm, ".q0"}, o.q0, eq0);
            chk({nm, ".i1"}, o.i1, ei1);
            chk({nm, ".q1"}, o.q1, eq1);
        end
    endtask

    task automatic send(input logic ld, input logic [31:0] pinc, input logic [15:0] x0,
                        input logic [15:0] x1, input logic [1:0] g, input logic cj,
                        output int dcyc);
        @(negedge clk);
        data = {x1, x0}; valid = 1'b1; load = ld; inc = pinc; gain = g; conj = cj;
        dcyc = cyc;
        @(posedge clk); #1;
        valid = 1'b0; load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        oq.delete();
    endtask

    // Three-beat stream at 90 degrees per sample; conj flips off on beat 2.
    task automatic run_stream(input int gap, input string nm);
        int d [3];
        oq.delete();
        send(1'b1, 32'h4000_0000, 16'd1000, 16'd1000, 2'd0, 1'b1, d[0]);
        repeat (gap) @(posedge clk);
        send(1'b0, 32'h0, 16'd1000, 16'd1000, 2'd0, 1'b1, d[1]);
        repeat (gap) @(posedge clk);
        send(1'b0, 32'h0, 16'd1000, 16'd1000, 2'd0, 1'b0, d[2]);
        chk_out({nm, ".b0"}, d[0],  1000, 0, 0, -1000);
        chk_out({nm, ".b1"}, d[1], -1000, 0, 0,  1000);
        chk_out({nm, ".b2"}, d[2],  1000, 0, 0,  1000);
    endtask

    typedef struct {
        logic [31:0] inc;
        logic [15:0] x0, x1;
        logic [1:0]  g;
        logic        cj;
        int          i0, q0, i1, q1;
        bit          sat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int exp_sat;
        data = '0; valid = 0; load = 0; inc = '0; gain = '0; conj = 0; sclr = 0;

        //           inc            x0          x1          g  cj   i0      q0  i1      q1     sat
        tbl[0]  = '{32'h0000_0000, 16'd16384,  16'd16384,  0, 0,   16384,  0,  16384,  0,     0};
        tbl[1]  = '{32'h4000_0000, 16'd1000,   16'd1000,   0, 1,   1000,   0,  0,      -1000, 0};
        tbl[2]  = '{32'h4000_0000, 16'd1000,   16'd1000,   0, 0,   1000,   0,  0,      1000,  0};
        tbl[3]  = '{32'h8000_0000, 16'd500,    -16'sd700,  0, 0,   500,    0,  700,    0,     0};
        tbl[4]  = '{32'hC000_0000, 16'd2000,   16'd2000,   0, 0,   2000,   0,  0,      -2000, 0};
        tbl[5]  = '{32'hC000_0000, 16'd2000,   16'd2000,   0, 1,   2000,   0,  0,      2000,  0};
        tbl[6]  = '{32'h0000_0000, 16'd3000,   -16'sd3000, 2, 0,   12000,  0,  -12000, 0,     0};
        tbl[7]  = '{32'h0000_0000, 16'd4000,   16'd5000,   3, 0,   32000,  0,  32767,  0,     1};
        tbl[8]  = '{32'h0000_0000, 16'd1,      -16'sd1,    0, 0,   1,      0,  -1,     0,     0};
        tbl[9]  = '{32'h3FFF_FFFF, 16'd1000,   16'd1000,   0, 0,   1000,   0,  6,      1000,  0};
        tbl[10] = '{32'h0000_0000, 16'h8000,   16'h8000,   1, 0,   -32768, 0,  -32768, 0,     1};
        tbl[11] = '{32'h0000_0000, 16'h8000,   16'd32767,  0, 0,   -32768, 0,  32767,  0,     0};

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst.valid", ovalid, 0);
        chk("rst.inph", inph, 0);
        chk("rst.quad", quad, 0);
        chk("rst.satcnt", scnt, 0);
        @(negedge clk); rst_n = 1'b1;

        // Single-beat vectors, each with a coincident phase load
        exp_sat = 0;
        for (int i = 0; i < 12; i++) begin
            oq.delete();
            send(1'b1, tbl[i].inc, tbl[i].x0, tbl[i].x1, tbl[i].g, tbl[i].cj, d);
            chk_out($sformatf("v%0d", i), d, tbl[i].i0, tbl[i].q0, tbl[i].i1, tbl[i].q1);
            if (tbl[i].sat) exp_sat++;
            chk($sformatf("v%0d.satcnt", i), scnt, exp_sat);
        end

        // Outputs hold once o_valid drops
        repeat (2) @(negedge clk); #1;
        chk("hold.valid", ovalid, 0);
        chk("hold.i0", $signed(inph[15:0]), -32768);
        chk("hold.i1", $signed(inph[31:16]), 32767);

        // Stream with and without idle gaps must give the same beats
        run_stream(0, "str");
        run_stream(3, "gap");

        // Saturating beat, then a clear that coincides with the next saturating beat
        do_reset();
        send(1'b1, 32'h0, 16'h8000, 16'h8000, 2'd1, 1'b0, d);
        chk_out("sat1", d, -32768, 0, -32768, 0);
        chk("sat1.satcnt", scnt, 1);
        send(1'b0, 32'h0, 16'h8000, 16'h8000, 2'd1, 1'b0, d);
        repeat (3) @(posedge clk);
        @(negedge clk); sclr = 1'b1;
        @(posedge clk); #1; sclr = 1'b0;
        chk("satclr.valid", ovalid, 1);
        chk("satclr.satcnt", scnt, 1);
        @(negedge clk); sclr = 1'b1;
        @(posedge clk); #1; sclr = 1'b0;
        chk("clr.satcnt", scnt, 0);
        oq.delete();

        // Reset with three beats in flight
        send(1'b0, 32'h0, 16'h8000, 16'h8000, 2'd1, 1'b0, d);
        chk_out("pre", d, -32768, 0, -32768, 0);
        chk("pre.satcnt", scnt, 1);
        send(1'b1, 32'h0, 16'd16384, 16'd16384, 2'd0, 1'b0, d);
        send(1'b0, 32'h0, 16'd16384, 16'd16384, 2'd0, 1'b0, d);
        send(1'b0, 32'h0, 16'd16384, 16'd16384, 2'd0, 1'b0, d);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", ovalid, 0);
        chk("midrst.inph", inph, 0);
        chk("midrst.quad", quad, 0);
        chk("midrst.satcnt", scnt, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("midrst.noout", oq.size(), 0);
        send(1'b1, 32'h0, 16'd16384, 16'd16384, 2'd0, 1'b0, d);
        chk_out("post", d, 16384, 0, 16384, 0);

        // Counter sticks at 65535 under a long run of saturating beats
        do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        data = {16'h8000, 16'h8000}; gain = 2'd1; conj = 1'b0; inc = '0;
        load = 1'b1; valid = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        repeat (65539) @(posedge clk);
        @(negedge clk); valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("sticky.satcnt", scnt, 65535);
        @(negedge clk); sclr = 1'b1;
        @(posedge clk); #1; sclr = 1'b0;
        chk("sticky.clr", scnt, 0);
        mon_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ddc_mixer_multilane.md
DDC_MIXER_MULTILANE -- requirements
Module: ddc_mixer_multilane

Interface
REQ-001 Param WIDTH, 16, signed sample width per lane, input and output.
REQ-002 Param LANES, 2, parallel samples per beat; 1..8.
REQ-003 Param COEF_WIDTH, 18, signed cos/sin coefficient width.
REQ-004 Param PHASE_WIDTH, 32, phase accumulator width.
REQ-005 Param LUT_BITS, 10, log2 of cos/sin table depth.
REQ-006 Clocking: one clock, i_clock; reset i_reset_n is asynchronous, active-low.
REQ-007 i_clock  in  1  sole clock.
REQ-008 i_reset_n  in  1  async active-low reset.
REQ-009 i_data  in  LANES*WIDTH  real samples; lane k at bits [k*WIDTH +: WIDTH], lane 0 oldest.
REQ-010 i_valid  in  1  beat qualifier for i_data.
REQ-011 i_phase_inc  in  PHASE_WIDTH  per-sample phase increment (unsigned, mod 2^PHASE_WIDTH).
REQ-012 i_phase_load  in  1  pulse: latch i_phase_inc, zero accumulator.
REQ-013 i_gain_shift  in  2  extra gain 2^i_gain_shift, sampled per beat.
REQ-014 i_conj  in  1  1: mix by e^-jθ (Q = -x·sin); 0: e^+jθ (Q = +x·sin); sampled per beat.
REQ-015 i_sat_clear  in  1  clears o_sat_count.
REQ-016 o_inph  out  LANES*WIDTH  I per lane, same packing as i_data.
REQ-017 o_quad  out  LANES*WIDTH  Q per lane.
REQ-018 o_valid  out  1  output beat qualifier.
REQ-019 o_sat_count  out  16  count of beats with any saturated lane/component.

Function
REQ-020 Phase: inc_reg, acc_reg (PHASE_WIDTH); lane k phase = acc_reg + k*inc_reg mod 2^PHASE_WIDTH.
REQ-021 On i_valid beat, acc_reg <= acc_reg + LANES*inc_reg; no i_valid -> acc_reg holds.
REQ-022 i_phase_load: inc_reg <= i_phase_inc, acc_reg <= 0; with coincident i_valid, that beat uses phase 0 and the new increment, acc_reg <= LANES*i_phase_inc.
REQ-023 Table index = top LUT_BITS bits of lane phase, truncated; cos[i] = round((2^(COEF_WIDTH-1)-1)·cos(2πi/2^LUT_BITS)), sin likewise; constant ROM fixed at elaboration.
REQ-024 Product = x·coef, full WIDTH+COEF_WIDTH signed; Q negated in full width when i_conj=1, before rounding.
REQ-025 Scale: y = floor((p + 2^(s-1)) / 2^s), s = COEF_WIDTH-1-i_gain_shift (round half up).
REQ-026 Saturate y to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap.
REQ-027 Fixed latency 5 cycles i_valid -> o_valid: input reg, table, multiply, round, saturate/output reg; no backpressure.
REQ-028 i_gain_shift, i_conj travel with their beat; mid-stream changes affect only subsequent beats.
REQ-029 o_inph/o_quad update only on o_valid beats, hold otherwise.
REQ-030 o_sat_count +1 per output beat with any saturation; sticks at 65535; i_sat_clear zeroes; clear with saturating beat same cycle -> 1.

Reset
REQ-031 i_reset_n low: o_valid, o_inph, o_quad, o_sat_count, acc_reg, inc_reg, pipeline valids -> 0 immediately.
REQ-032 No beat in flight at reset emerges after release; first o_valid 5 cycles after first post-reset i_valid.

Verification (WIDTH=16, LANES=2, COEF_WIDTH=18, PHASE_WIDTH=32, LUT_BITS=10)
REQ-033 load inc=0, both lanes 16384, shift 0 -> 5 cycles later o_valid=1, I=16384 both lanes, Q=0.
REQ-034 load inc=0x40000000, x=1000, conj=1, two beats -> beat0 lane0 (1000,0), lane1 (0,-1000); beat1 lane0 (-1000,0), lane1 (0,1000).
REQ-035 inc=0, x=-32768 both lanes, shift=1 -> I=-32768 saturated, o_sat_count=1; next beat with i_sat_clear -> count 1.
REQ-036 inc=0x40000000, i_valid gaps of 3 idle cycles -> outputs identical to gap-free run, phase advances only on valid beats.
REQ-037 i_reset_n low with 3 beats in flight -> outputs 0 immediately, no o_valid after release until new input +5.
REQ-038 force 65535 saturating beats -> o_sat_count stays 65535; i_sat_clear -> 0.
